buffered_router: RTL and testbench

Parametrised, buffered 1-to-N packet router and the next generation of the combinational header-demux router. It accepts one packet per cycle on a valid/ready input and stores it in an input FIFO. The top log2(p_noutputs) bits of each packet select a destination, and the packet is delivered, with its header removed, through a one-entry output register per channel. Input readiness depends only on FIFO space, never combinationally on downstream ready. It sits between the interconnect front end and the per-block consumers.

---
 rtl/buffered_router.sv | 105 ++++++++++
 tb/tb_buffered_router.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/buffered_router.sv
// Buffered 1-to-N packet router: input FIFO feeding one-entry output registers per channel.
// The header (top bits) of the FIFO head selects the channel; the payload is the remaining low bits.
module buffered_router #(
  parameter int unsigned p_nbits    = 32,
  parameter int unsigned p_noutputs = 8,
  parameter int unsigned p_depth    = 4
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic                                        valid,
  input  logic [p_nbits-1:0]                          message_in,
  output logic                                        ready_out,
  output logic [p_noutputs-1:0]                       valid_out,
  input  logic [p_noutputs-1:0]                       ready,
  output logic [p_nbits-$clog2(p_noutputs)-1:0]       message_out [p_noutputs],
  output logic [$clog2(p_depth):0]                    occupancy
);

  localparam int unsigned HdrW = $clog2(p_noutputs);
  localparam int unsigned PayW = p_nbits - HdrW;
  localparam int unsigned PtrW = $clog2(p_depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [p_nbits-1:0]    mem_q [p_depth];
  logic [p_nbits-1:0]    mem_d [p_depth];
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]       count_q, count_d;
  logic [p_noutputs-1:0] vld_q, vld_d;
  logic [PayW-1:0]       msg_q [p_noutputs];
  logic [PayW-1:0]       msg_d [p_noutputs];

  logic                  enq;
  logic                  deq;
  logic                  not_empty;
  logic [p_nbits-1:0]    head;
  logic [HdrW-1:0]       sel;

  // Readiness comes from the registered count only, so a dequeue while full cannot bypass.
  always_comb begin
    ready_out = (count_q != CntW'(p_depth));
    not_empty = (count_q != '0);
    enq       = valid && ready_out;
    head      = mem_q[rd_ptr_q];
    sel       = head[p_nbits-1 -: HdrW];
    deq       = not_empty && (!vld_q[sel] || ready[sel]);
  end

  always_comb begin
    mem_d = mem_q;
    if (enq) begin
      mem_d[wr_ptr_q] = message_in;
    end
    // Pointer width equals log2(depth), so the increment wraps modulo depth.
    wr_ptr_d = enq ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = deq ? rd_ptr_q + 1'b1 : rd_ptr_q;
    unique case ({enq, deq})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // A load takes priority over a drain: the new packet replaces a departing one.
  always_comb begin
    vld_d = vld_q;
    msg_d = msg_q;
    for (int unsigned i = 0; i < p_noutputs; i++) begin
      if (deq && (sel == HdrW'(i))) begin
        vld_d[i] = 1'b1;
        msg_d[i] = head[PayW-1:0];
      end else if (vld_q[i] && ready[i]) begin
        vld_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      vld_q    <= '0;
      for (int unsigned i = 0; i < p_noutputs; i++) begin
        msg_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      vld_q    <= vld_d;
      msg_q    <= msg_d;
    end
  end

  // Storage needs no reset; the count alone decides which entries are live.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign valid_out   = vld_q;
  assign message_out = msg_q;
  assign occupancy   = count_q;

endmodule

// File: tb/tb_buffered_router.sv
// Bench for buffered_router: directed scenarios then random traffic, checked against a
// queue-based reference model of the FIFO and per-channel output slots.
module tb_buffered_router;

  localparam int NB = 32;
  localparam int NO = 8;
  localparam int DP = 4;
  localparam int PW = 29;

  logic          clk = 1'b0;
  logic          reset;
  logic          valid;
  logic [NB-1:0] message_in;
  logic          ready_out;
  logic [NO-1:0] valid_out;
  logic [NO-1:0] ready;
  logic [PW-1:0] message_out [NO];
  logic [2:0]    occupancy;

  int tests = 0;
  int fails = 0;

  logic [NB-1:0] m_fifo [$];
  logic [NO-1:0] m_vld;
  logic [PW-1:0] m_msg [NO];
  bit            m_acc;

  logic [NB-1:0] pk [6];
  int            k;

  buffered_router #(.p_nbits(NB), .p_noutputs(NO), .p_depth(DP)) dut (
    .clk        (clk),
    .reset      (reset),
    .valid      (valid),
    .message_in (message_in),
    .ready_out  (ready_out),
    .valid_out  (valid_out),
    .ready      (ready),
    .message_out(message_out),
    .occupancy  (occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_fifo.delete();
    m_vld = '0;
    for (int i = 0; i < NO; i++) m_msg[i] = '0;
    m_acc = 0;
  endtask

  // One clock edge of the reference: dispatch the head if its channel can take it,
  // retire drained outputs, and accept the input if there was room before the edge.
  task automatic model_edge();
    bit            room;
    bit            fire;
    int            ch;
    logic [NB-1:0] p;
    if (!reset) begin
      model_reset();
      return;
    end
    room  = (m_fifo.size() != DP);
    fire  = 0;
    ch    = 0;
    m_acc = 0;
    if (m_fifo.size() > 0) begin
      p    = m_fifo[0];
      ch   = int'(p[NB-1:NB-3]);
      fire = !m_vld[ch] || ready[ch];
    end
    for (int i = 0; i < NO; i++) begin
      if (m_vld[i] && ready[i]) m_vld[i] = 1'b0;
    end
    if (fire) begin
      p         = m_fifo.pop_front();
      m_vld[ch] = 1'b1;
      m_msg[ch] = p[PW-1:0];
    end
    if (valid && room) begin
      m_fifo.push_back(message_in);
      m_acc = 1;
    end
  endtask

  task automatic check_all();
    chk("ready_out", 64'(ready_out), 64'(m_fifo.size() != DP));
    chk("valid_out", 64'(valid_out), 64'(m_vld));
    chk("occupancy", 64'(occupancy), 64'(m_fifo.size()));
    for (int i = 0; i < NO; i++) begin
      chk($sformatf("message_out[%0d]", i), 64'(message_out[i]), 64'(m_msg[i]));
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  // Reset pulse between edges; outputs must clear before any clock edge.
  task automatic async_pulse();
    #1 reset = 1'b0;
    model_reset();
    #1;
    check_all();
    chk("async_valid_out", 64'(valid_out), 64'h0);
    #1 reset = 1'b1;
  endtask

  function automatic logic [NB-1:0] mkpkt(input int hdr);
    logic [NB-1:0] w;
    w = $urandom;
    w[NB-1:NB-3] = 3'(hdr);
    return w;
  endfunction

  initial begin
    reset      = 1'b0;
    valid      = 1'b0;
    message_in = '0;
    ready      = 8'hFF;
    model_reset();

    // Reset / idle
    repeat (3) cycle();
    chk("rst_ready_out", 64'(ready_out), 64'h1);
    chk("rst_valid_out", 64'(valid_out), 64'h0);
    chk("rst_occupancy", 64'(occupancy), 64'h0);
    reset = 1'b1;
    cycle();

    // Single packet to channel 5
    valid = 1'b1; message_in = 32'hA000_1234;
    cycle();
    valid = 1'b0;
    cycle();
    chk("single_valid", 64'(valid_out), 64'h20);
    chk("single_msg", 64'(message_out[5]), 64'h0000_1234);
    cycle();
    chk("single_drain", 64'(valid_out), 64'h0);

    // Back-to-back, headers 0..7
    for (int i = 0; i < NO; i++) begin
      valid = 1'b1; message_in = mkpkt(i);
      cycle();
      chk("b2b_occ_le1", 64'(occupancy <= 3'd1), 64'h1);
      chk("b2b_ready_out", 64'(ready_out), 64'h1);
    end
    valid = 1'b0;
    repeat (3) cycle();

    // Fill and back-pressure on channel 2
    ready = 8'hFB;
    for (int i = 0; i < 6; i++) pk[i] = mkpkt(2);
    k = 0;
    repeat (8) begin
      valid = 1'b1; message_in = pk[k];
      cycle();
      if (m_acc && k < 5) k++;
    end
    chk("full_occupancy", 64'(occupancy), 64'h4);
    chk("full_ready_out", 64'(ready_out), 64'h0);
    chk("full_out2", 64'(message_out[2]), 64'(pk[0][PW-1:0]));
    ready = 8'hFF;
    cycle();
    chk("unfull_ready_out", 64'(ready_out), 64'h1);
    chk("unfull_out2", 64'(message_out[2]), 64'(pk[1][PW-1:0]));
    for (int n = 0; n < 10 && !m_acc; n++) cycle();
    valid = 1'b0;
    repeat (8) cycle();

    // Head-of-line blocking
    ready = 8'hFD;
    valid = 1'b1;
    message_in = mkpkt(1); cycle();
    message_in = mkpkt(1); cycle();
    message_in = mkpkt(3); cycle();
    valid = 1'b0;
    repeat (4) begin
      cycle();
      chk("hol_valid3", 64'(valid_out[3]), 64'h0);
    end
    ready = 8'hFF;
    repeat (5) cycle();

    // Async reset mid-operation
    ready = 8'hEF;
    valid = 1'b1;
    repeat (4) begin
      message_in = mkpkt(4); cycle();
    end
    valid = 1'b0;
    cycle();
    chk("pre_rst_occ", 64'(occupancy), 64'h3);
    chk("pre_rst_v4", 64'(valid_out[4]), 64'h1);
    async_pulse();
    ready = 8'hFF;
    repeat (6) begin
      cycle();
      chk("post_rst_valid", 64'(valid_out), 64'h0);
    end

    // Random traffic
    repeat (800) begin
      valid      = ($urandom_range(0, 3) != 0);
      message_in = $urandom;
      if ($urandom_range(0, 3) == 0) ready = 8'($urandom);
      else if ($urandom_range(0, 1) == 0) ready = 8'hFF;
      else ready = 8'hFF ^ (8'h1 << $urandom_range(0, 7));
      cycle();
      if ($urandom_range(0, 199) == 0) async_pulse();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
